// File: rtl/xip_read_cache_pkg.sv
// Shared definitions for the XIP read cache.
// Contents: FSM state encoding, default cacheable window bounds and the
// index/tag width derivation used by the top level and the line storage.
package xip_read_cache_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HIT        = 3'd1,
    FWD_SETUP  = 3'd2,
    FWD_ACCESS = 3'd3,
    RESP       = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_FLASH_BASE = 32'h3000_0000;
  localparam logic [31:0] DEFAULT_FLASH_END  = 32'h3fff_ffff;

  // Lines hold one 32-bit word, so the index starts at byte-address bit 2.
  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines);
    return 30 - $clog2(lines);
  endfunction

endpackage

// File: rtl/xip_read_cache_if.sv
// APB bundle around the XIP read cache.
// in_*  : APB slave side facing the CPU crossbar (request in, response out).
// out_* : APB master side facing the SPI/flash bridge (request out, response in).
// Modport slave is the cache's view; modport master is the surrounding
// system's view (CPU crossbar plus downstream bridge).
interface xip_read_cache_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr,
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    input  out_pready, out_prdata, out_pslverr
  );

  modport master (
    output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr,
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    output out_pready, out_prdata, out_pslverr
  );
endinterface

// File: rtl/xip_cache_array.sv
// Direct-mapped tag/data/valid storage for the XIP read cache.
// Ports: clock, reset (async active-low), flush (clear all valid bits),
// rd_index -> rd_valid/rd_tag/rd_data (combinational read),
// wr_en/wr_index/wr_tag/wr_data (synchronous write, sets the line valid).
module xip_cache_array
  import xip_read_cache_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IDX_W = index_width(LINES),
  parameter int TAG_W = tag_width(LINES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0]      data_mem [LINES];
  logic             valid_reg [LINES];

  // Tag and data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  // Flush takes priority over a fill landing in the same cycle.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_reg[gi] <= 1'b0;
      end else if (flush) begin
        valid_reg[gi] <= 1'b0;
      end else if (wr_en && (wr_index == IDX_W'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/xip_read_cache.sv
// XIP read cache: one-word direct-mapped read cache between the CPU APB
// crossbar and the SPI/flash APB bridge. Reads in the flash window are served
// from the cache on a hit (zero wait states) or fetched downstream on a miss;
// writes to the flash window are rejected with PSLVERR; everything outside
// the window is forwarded untouched.
// Ports: clock, reset (async active-low), bus (in_* slave / out_* master APB),
// flush (single-cycle invalidate-all), hit_cnt/miss_cnt (wrapping counters).
module xip_read_cache
  import xip_read_cache_pkg::*;
#(
  parameter int          LINES      = 4,
  parameter logic [31:0] FLASH_BASE = DEFAULT_FLASH_BASE,
  parameter logic [31:0] FLASH_END  = DEFAULT_FLASH_END
) (
  input  logic                    clock,
  input  logic                    reset,
  xip_read_cache_if.slave         bus,
  input  logic                    flush,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int IDX_W = index_width(LINES);
  localparam int TAG_W = tag_width(LINES);

  state_t            state_reg;
  logic              fill_reg;        // current forward is a cacheable miss
  logic              kill_reg;        // flush seen while the fill was in flight
  logic [IDX_W-1:0]  fill_index_reg;
  logic [TAG_W-1:0]  fill_tag_reg;

  logic              in_pready_reg, in_pslverr_reg;
  logic [31:0]       in_prdata_reg;
  logic [31:0]       out_paddr_reg, out_pwdata_reg;
  logic              out_psel_reg, out_penable_reg, out_pwrite_reg;
  logic [2:0]        out_pprot_reg;
  logic [3:0]        out_pstrb_reg;
  logic [31:0]       hit_cnt_reg, miss_cnt_reg;

  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              cacheable, setup, hit, wr_en;

  assign req_index = bus.in_paddr[2 +: IDX_W];
  assign req_tag   = bus.in_paddr[31 -: TAG_W];
  assign cacheable = (bus.in_paddr >= FLASH_BASE) && (bus.in_paddr <= FLASH_END);
  assign setup     = bus.in_psel && !bus.in_penable;
  assign hit       = rd_valid && (rd_tag == req_tag);

  // The fill is committed as RESP retires so that a flush arriving during
  // RESP can still cancel it; the array also gives flush priority.
  assign wr_en = (state_reg == RESP) && fill_reg && !kill_reg && !in_pslverr_reg && !flush;

  xip_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (fill_index_reg),
    .wr_tag   (fill_tag_reg),
    .wr_data  (in_prdata_reg)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      fill_reg        <= 1'b0;
      kill_reg        <= 1'b0;
      fill_index_reg  <= '0;
      fill_tag_reg    <= '0;
      in_pready_reg   <= 1'b0;
      in_pslverr_reg  <= 1'b0;
      in_prdata_reg   <= '0;
      out_paddr_reg   <= '0;
      out_psel_reg    <= 1'b0;
      out_penable_reg <= 1'b0;
      out_pprot_reg   <= '0;
      out_pwrite_reg  <= 1'b0;
      out_pwdata_reg  <= '0;
      out_pstrb_reg   <= '0;
      hit_cnt_reg     <= '0;
      miss_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (setup) begin
            if (cacheable && bus.in_pwrite) begin
              // Flash is read-only through this path: fail fast, no downstream access.
              state_reg      <= HIT;
              in_pready_reg  <= 1'b1;
              in_pslverr_reg <= 1'b1;
              in_prdata_reg  <= '0;
            end else if (cacheable && hit) begin
              state_reg      <= HIT;
              in_pready_reg  <= 1'b1;
              in_pslverr_reg <= 1'b0;
              in_prdata_reg  <= rd_data;
              hit_cnt_reg    <= hit_cnt_reg + 32'd1;
            end else begin
              state_reg       <= FWD_SETUP;
              out_psel_reg    <= 1'b1;
              out_penable_reg <= 1'b0;
              out_paddr_reg   <= cacheable ? {bus.in_paddr[31:2], 2'b00} : bus.in_paddr;
              out_pwrite_reg  <= cacheable ? 1'b0 : bus.in_pwrite;
              out_pstrb_reg   <= cacheable ? 4'b0000 : bus.in_pstrb;
              out_pwdata_reg  <= bus.in_pwdata;
              out_pprot_reg   <= bus.in_pprot;
              fill_reg        <= cacheable;
              kill_reg        <= 1'b0;
              fill_index_reg  <= req_index;
              fill_tag_reg    <= req_tag;
              if (cacheable) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
              end
            end
          end
        end
        HIT: begin
          state_reg      <= IDLE;
          in_pready_reg  <= 1'b0;
          in_pslverr_reg <= 1'b0;
          in_prdata_reg  <= '0;
        end
        FWD_SETUP: begin
          state_reg       <= FWD_ACCESS;
          out_penable_reg <= 1'b1;
          if (flush) kill_reg <= 1'b1;
        end
        FWD_ACCESS: begin
          if (flush) kill_reg <= 1'b1;
          if (bus.out_pready) begin
            state_reg       <= RESP;
            out_psel_reg    <= 1'b0;
            out_penable_reg <= 1'b0;
            in_pready_reg   <= 1'b1;
            in_prdata_reg   <= bus.out_prdata;
            in_pslverr_reg  <= bus.out_pslverr;
          end
        end
        RESP: begin
          state_reg      <= IDLE;
          in_pready_reg  <= 1'b0;
          in_pslverr_reg <= 1'b0;
          in_prdata_reg  <= '0;
          fill_reg       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_pready   = in_pready_reg;
  assign bus.in_prdata   = in_prdata_reg;
  assign bus.in_pslverr  = in_pslverr_reg;
  assign bus.out_paddr   = out_paddr_reg;
  assign bus.out_psel    = out_psel_reg;
  assign bus.out_penable = out_penable_reg;
  assign bus.out_pprot   = out_pprot_reg;
  assign bus.out_pwrite  = out_pwrite_reg;
  assign bus.out_pwdata  = out_pwdata_reg;
  assign bus.out_pstrb   = out_pstrb_reg;
  assign hit_cnt         = hit_cnt_reg;
  assign miss_cnt        = miss_cnt_reg;

endmodule

// File: doc/xip_read_cache.md
XIP_READ_CACHE -- requirements
Module: xip_read_cache

Interface
REQ-001 SHALL have parameter LINES, default 4, number of one-word direct-mapped lines (power of two, 2..64).
REQ-002 SHALL have parameter FLASH_BASE, default 32'h30000000, first cacheable byte address.
REQ-003 SHALL have parameter FLASH_END, default 32'h3fffffff, last cacheable byte address.
REQ-004 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low (asserted at 0).
REQ-005 SHALL have ports: in_paddr in 32, in_psel in 1, in_penable in 1, in_pprot in 3, in_pwrite in 1, in_pwdata in 32, in_pstrb in 4. Together these form the APB slave request from the CPU crossbar.
REQ-006 SHALL have ports: in_pready out 1, in_prdata out 32, in_pslverr out 1. Together these form the APB slave response.
REQ-007 SHALL have ports: out_paddr out 32, out_psel out 1, out_penable out 1, out_pprot out 3, out_pwrite out 1, out_pwdata out 32, out_pstrb out 4. Together these form the APB master request to the downstream SPI/flash bridge.
REQ-008 SHALL have ports: out_pready in 1, out_prdata in 32, out_pslverr in 1. Together these form the APB master response.
REQ-009 SHALL have ports: flush in 1 (single-cycle invalidate-all request), hit_cnt out 32, miss_cnt out 32.

Function
REQ-010 SHALL run FSM states IDLE, HIT, FWD_SETUP, FWD_ACCESS and RESP. Every output SHALL be registered.
REQ-011 IDLE: on in_psel=1 and in_penable=0, SHALL classify the request from in_paddr: cacheable (FLASH_BASE <= addr <= FLASH_END) or pass-through.
REQ-012 Line index SHALL be in_paddr[2+log2(LINES)-1:2]. Tag SHALL be in_paddr[31:2+log2(LINES)]. Hit SHALL mean valid[index] is set and the stored tag matches.
REQ-013 A cacheable read hit SHALL go to HIT. In the next cycle (the first access-phase cycle) in_pready=1 and in_prdata=the line data. This gives zero wait states.
REQ-014 A cacheable write SHALL complete with in_pready=1 and in_pslverr=1 in the first access-phase cycle. It SHALL generate no downstream transfer and leave the cache unchanged.
REQ-015 A cacheable read miss and any pass-through access SHALL go to FWD_SETUP and drive out_psel=1, out_penable=0.
REQ-016 In FWD_SETUP, out_paddr SHALL be the request address; for cacheable misses, bits [1:0] SHALL be forced to 0.
REQ-017 In FWD_SETUP, out_pwrite, out_pwdata, out_pstrb and out_pprot SHALL be copies of the request. A cacheable miss SHALL force out_pwrite=0 and out_pstrb=0.
REQ-018 FWD_ACCESS SHALL hold out_psel=1 and out_penable=1 and keep all request fields stable until out_pready=1.
REQ-019 On out_pready=1, the block SHALL capture out_prdata and out_pslverr, drop out_psel and out_penable in the next cycle, and go to RESP.
REQ-020 RESP SHALL drive in_pready=1 for exactly one cycle with the captured data and error, then return to IDLE.
REQ-021 A cacheable miss with out_pslverr=0 SHALL write the data, tag and valid bit into the line on completion. With out_pslverr=1 it SHALL not allocate.
REQ-022 Pass-through accesses SHALL never read or modify the cache.
REQ-023 hit_cnt SHALL increment once per cacheable read hit. miss_cnt SHALL increment once per cacheable read miss. Both SHALL wrap from 32'hffffffff to 0.
REQ-024 flush=1 in IDLE or HIT SHALL clear all valid bits in that cycle. A lookup in the same cycle SHALL use the pre-flush state.
REQ-025 flush=1 during FWD_SETUP, FWD_ACCESS or RESP SHALL clear all valid bits and suppress allocation of the fill in progress. The response SHALL still be returned.
REQ-026 A new in_psel setup SHALL only be accepted in IDLE. The upstream master holds the request per APB, so no request is lost.

Reset
REQ-027 While reset=0, the block SHALL be in state IDLE and all valid bits SHALL be 0.
REQ-028 While reset=0, every output (out_*, in_pready, in_prdata, in_pslverr, hit_cnt, miss_cnt) SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL abort it immediately with no response. Operation SHALL resume in the first cycle after reset=1.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the default FLASH_BASE and FLASH_END constants, and the tag/index width derivation.
REQ-031 Tag, data and valid storage SHALL be one sub-module, xip_cache_array, with one combinational read port and one synchronous write port plus a flush-all input.

Verification
REQ-032 Read 0x30000010 with downstream returning 0xDEADBEEF after 5 wait cycles -> in_prdata=0xDEADBEEF, miss_cnt=1, one downstream transfer at 0x30000010.
REQ-033 Repeat the read of 0x30000010 -> in_pready=1 in the first access cycle, in_prdata=0xDEADBEEF, hit_cnt=1, no downstream transfer.
REQ-034 With LINES=4, read 0x30000010 then 0x30000050 (same index, different tag) then 0x30000010 -> three misses, miss_cnt=3.
REQ-035 Write 0x30000000 -> in_pslverr=1, in_pready=1 with zero wait states, out_psel never asserted.
REQ-036 Write 0x10001018 with data 0x1 and strobe 0xF -> a downstream write with identical fields, response forwarded, counters unchanged.
REQ-037 Pulse flush during FWD_ACCESS of a miss to 0x30000020, then read 0x30000020 again -> both reads miss, miss_cnt=2.
